lfsr_stream: RTL and testbench

- Programmable LFSR pattern generator for the multiplier test datapath; successor to the single-mode free-running LFSR.
- Adds selectable Fibonacci or Galois form, latched configuration, and a bounded-length run.
- Drives a valid/ready output stream, with lock-up detection on the all-zero state.
- Feeds operand words to the multiplier bench and any consumer that can apply backpressure.

---
 rtl/lfsr_pkg.sv | 6 +
 rtl/lfsr_stream_if.sv | 8 +
 rtl/lfsr_next.sv | 11 +
 rtl/lfsr_stream.sv | 81 ++++++++
 tb/tb_lfsr_stream.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state and mode encodings for the LFSR stream generator
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;
endpackage

// File: rtl/lfsr_stream_if.sv
// lfsr_stream_if: valid/ready output stream carrying LFSR words
interface lfsr_stream_if #(parameter int N = 32);
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_data;
  modport master(output out_valid, out_data, input out_ready);
  modport slave(input out_valid, out_data, output out_ready);
endinterface

// File: rtl/lfsr_next.sv
// lfsr_next: one-step Fibonacci or Galois LFSR next-state function
module lfsr_next #(parameter int N = 32) (
  input  logic [N-1:0] state,
  input  logic [N-1:0] mask,
  input  logic         galois,
  output logic [N-1:0] next
);
  // Galois folds the mask in on the outgoing MSB; Fibonacci shifts in the tap parity
  always_comb next = galois ? ({state[N-2:0], 1'b0} ^ (state[N-1] ? mask : '0))
                            : {state[N-2:0], ^(state & mask)};
endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: programmable LFSR word generator with bounded runs and lock-up detection
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int          N        = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] DEF_MASK = 32'h80200003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_seed,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cfg_galois,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             lockup_err,
  lfsr_stream_if.master    out
);
  state_t state, state_n;
  logic [N-1:0] seed_r, mask_r, lfsr_r, nxt;
  logic [CNT_W-1:0] cnt_r, rem_r;
  logic gal_r, load, go, fire, last;

  lfsr_next #(.N(N)) u_next (.state(lfsr_r), .mask(mask_r), .galois(gal_r), .next(nxt));

  assign load = state == IDLE && cfg_load;
  assign go   = state == IDLE && start && !cfg_load;
  assign fire = state == RUN && out.out_ready;
  assign last = fire && (nxt == '0 || (cnt_r != '0 && rem_r == CNT_W'(1)));

  assign out.out_valid = state == RUN;
  assign out.out_data  = lfsr_r;
  assign busy          = state == RUN;
  assign done          = state == DONE;

  // FSM state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  // next state: a zero seed never leaves IDLE; DONE always lasts one cycle
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? ((go && seed_r != '0) ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
  end

  // configuration latch, LFSR register, run counter and sticky lock-up flag
  always_ff @(posedge clk)
    if (rst) begin
      seed_r     <= N'(1);
      mask_r     <= DEF_MASK[N-1:0];
      gal_r      <= MODE_FIB;
      cnt_r      <= '0;
      rem_r      <= '0;
      lfsr_r     <= N'(1);
      lockup_err <= 1'b0;
    end else begin
      if (load) begin
        seed_r     <= cfg_seed;
        mask_r     <= cfg_mask;
        gal_r      <= cfg_galois;
        cnt_r      <= cfg_count;
        lockup_err <= 1'b0;
      end
      if (go && seed_r == '0) lockup_err <= 1'b1;
      if (go && seed_r != '0) begin
        lfsr_r <= seed_r;
        rem_r  <= cnt_r;
      end
      if (fire) begin
        lfsr_r <= nxt;
        if (cnt_r != '0) rem_r <= rem_r - CNT_W'(1);
        if (nxt == '0) lockup_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: scoreboard bench for the LFSR stream generator at N=8
module tb_lfsr_stream;
  logic clk = 0, rst = 1, cfg_load = 0, cfg_galois = 0, start = 0, rdy = 1;
  logic [7:0] cfg_seed = 0, cfg_mask = 0;
  logic [15:0] cfg_count = 0;
  logic busy, done, lockup_err;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic stall_prev = 0;
  logic [7:0] data_prev = 0;

  lfsr_stream_if #(.N(8)) sif();
  assign sif.out_ready = rdy;

  lfsr_stream #(.N(8), .CNT_W(16), .DEF_MASK(32'h80200003)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_seed(cfg_seed), .cfg_mask(cfg_mask),
    .cfg_galois(cfg_galois), .cfg_count(cfg_count), .start(start), .busy(busy),
    .done(done), .lockup_err(lockup_err), .out(sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every handshake and checks stalls hold the word
  always @(negedge clk) begin
    if (!rst && stall_prev) begin
      chk("hold_data", sif.out_data, data_prev);
      chk("hold_valid", sif.out_valid, 1);
    end
    if (!rst && sif.out_valid && sif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h expected none", sif.out_data);
      end else chk("word", sif.out_data, exp_q.pop_front());
    end
    stall_prev = !rst && sif.out_valid && !sif.out_ready;
    data_prev  = sif.out_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] s, input logic [7:0] m, input logic g, input logic [15:0] c);
    cfg_seed = s; cfg_mask = m; cfg_galois = g; cfg_count = c; cfg_load = 1;
    tick;
    cfg_load = 0;
  endtask

  task automatic go;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_done(input int exp_cycles, input string name);
    int n = 0;
    while (!done && n < 1000) begin
      tick;
      n++;
    end
    chk({name, "_cycles"}, n, exp_cycles);
    chk({name, "_done_busy"}, busy, 0);
    chk({name, "_done_valid"}, sif.out_valid, 0);
    tick;
    chk({name, "_done_once"}, done, 0);
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic push_fib;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    exp_q.push_back(8'h08); exp_q.push_back(8'h11); exp_q.push_back(8'h23);
  endtask

  initial begin
    logic [7:0] seen[256];
    logic [7:0] x;
    int dups, zeros;
    logic done_seen;
    repeat (2) tick;
    rst = 0;
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_data", sif.out_data, 8'h01);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lockup", lockup_err, 0);

    cfg(8'h01, 8'hB8, 0, 6);
    push_fib();
    go;
    chk("fib_busy", busy, 1);
    wait_done(6, "fib");
    chk("fib_final", sif.out_data, 8'h47);

    cfg(8'h80, 8'h1D, 1, 5);
    exp_q.push_back(8'h80); exp_q.push_back(8'h1D); exp_q.push_back(8'h3A);
    exp_q.push_back(8'h74); exp_q.push_back(8'hE8);
    go;
    wait_done(5, "gal");
    chk("gal_final", sif.out_data, 8'hCD);

    cfg(8'h01, 8'hB8, 0, 6);
    push_fib();
    go;
    tick;
    tick;
    chk("bp_word", sif.out_data, 8'h04);
    rdy = 0;
    repeat (3) begin
      tick;
      chk("bp_stall_data", sif.out_data, 8'h04);
      chk("bp_stall_valid", sif.out_valid, 1);
    end
    rdy = 1;
    wait_done(4, "bp");

    cfg(8'h00, 8'hB8, 0, 4);
    go;
    chk("zs_lockup", lockup_err, 1);
    chk("zs_busy", busy, 0);
    chk("zs_valid", sif.out_valid, 0);
    chk("zs_done", done, 0);
    tick;
    chk("zs_done2", done, 0);
    chk("zs_busy2", busy, 0);
    cfg(8'h80, 8'h00, 1, 0);
    chk("zs_clear", lockup_err, 0);

    exp_q.push_back(8'h80);
    go;
    wait_done(1, "lock");
    chk("lock_err", lockup_err, 1);

    cfg(8'h01, 8'hB8, 0, 6);
    push_fib();
    go;
    tick;
    cfg_seed = 8'h55; cfg_mask = 8'h1D; cfg_galois = 1; cfg_count = 2;
    cfg_load = 1; start = 1;
    tick;
    cfg_load = 0; start = 0;
    wait_done(4, "mid");
    push_fib();
    go;
    wait_done(6, "mid_rerun");

    cfg(8'h01, 8'hB8, 0, 6);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    go;
    tick;
    tick;
    chk("rr_third", sif.out_data, 8'h04);
    rst = 1;
    tick;
    rst = 0;
    chk("rr_valid", sif.out_valid, 0);
    chk("rr_data", sif.out_data, 8'h01);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_lockup", lockup_err, 0);
    chk("rr_q_empty", exp_q.size(), 0);
    tick;
    chk("rr_done2", done, 0);

    cfg(8'h01, 8'hB8, 0, 0);
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(x);
      x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
    go;
    done_seen = 0;
    for (int i = 0; i < 256; i++) begin
      seen[i] = sif.out_data;
      if (done) done_seen = 1;
      tick;
    end
    dups = 0;
    zeros = 0;
    for (int i = 0; i < 255; i++) begin
      if (seen[i] == 8'h00) zeros++;
      for (int j = i + 1; j < 255; j++) if (seen[i] == seen[j]) dups++;
    end
    chk("free_done", done_seen, 0);
    chk("free_busy", busy, 1);
    chk("free_dups", dups, 0);
    chk("free_zeros", zeros, 0);
    chk("free_wrap", seen[255], 8'h01);
    rst = 1;
    tick;
    rst = 0;
    chk("free_q_empty", exp_q.size(), 0);
    chk("free_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
